// File: rtl/ps2_key_ctrl.sv
// PS/2 scan-code decoder feeding an event FIFO of {break, extended, code}.
// Optional typematic repeat filter: define PS2_KEY_CTRL_TYPEMATIC_FILTER_EN.
module ps2_key_ctrl #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_enable,
  output logic       o_ps2_enable,
  input  logic [7:0] i_key,
  input  logic       i_key_valid,
  input  logic       i_error,
  input  logic       i_rd,
  input  logic       i_clear,
  output logic [9:0] o_event,
  output logic       o_empty,
  output logic       o_full,
  output logic [6:0] o_count,
  output logic       o_overflow,
  output logic [7:0] o_err_count
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_E0,
    S_F0,
    S_E0F0,
    S_PAUSE
  } state_t;

  state_t     state, state_nxt;
  logic [2:0] skip, skip_nxt;
  logic       push_req;
  logic       pause_evt;
  logic [9:0] push_data;
  logic       wr_req;

  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [6:0]    count;
  logic          do_push, do_pop;

  // ---------------- decoder FSM ----------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
      skip  <= '0;
    end else begin
      state <= state_nxt;
      skip  <= skip_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    skip_nxt  = skip;
    push_req  = 1'b0;
    pause_evt = 1'b0;
    push_data = '0;
    if (!i_enable || i_error) begin
      state_nxt = S_IDLE;
      skip_nxt  = '0;
    end else if (i_key_valid) begin
      unique case (state)
        S_IDLE: begin
          if (i_key == 8'hE0) begin
            state_nxt = S_E0;
          end else if (i_key == 8'hF0) begin
            state_nxt = S_F0;
          end else if (i_key == 8'hE1) begin
            state_nxt = S_PAUSE;
            skip_nxt  = 3'd7;
          end else begin
            push_req  = 1'b1;
            push_data = {2'b00, i_key};
          end
        end
        S_E0: begin
          if (i_key == 8'hF0) begin
            state_nxt = S_E0F0;
          end else begin
            push_req  = 1'b1;
            push_data = {2'b01, i_key};
            state_nxt = S_IDLE;
          end
        end
        S_F0: begin
          push_req  = 1'b1;
          push_data = {2'b10, i_key};
          state_nxt = S_IDLE;
        end
        S_E0F0: begin
          push_req  = 1'b1;
          push_data = {2'b11, i_key};
          state_nxt = S_IDLE;
        end
        S_PAUSE: begin
          // The pause sequence is reported once its seventh trailing byte arrives
          skip_nxt = skip - 3'd1;
          if (skip <= 3'd1) begin
            skip_nxt  = '0;
            push_req  = 1'b1;
            pause_evt = 1'b1;
            push_data = {2'b01, 8'h77};
            state_nxt = S_IDLE;
          end
        end
        default: begin
          state_nxt = S_IDLE;
          skip_nxt  = '0;
        end
      endcase
    end
  end

  // ---------------- typematic filter ----------------
`ifdef PS2_KEY_CTRL_TYPEMATIC_FILTER_EN
  logic [8:0] held;
  logic       held_valid;
  logic       filt_drop;
  logic       held_match;

  always_comb begin
    held_match = held_valid && (held == push_data[8:0]);
    filt_drop  = push_req && !pause_evt && !push_data[9] && held_match;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      held       <= '0;
      held_valid <= 1'b0;
    end else if (push_req && !pause_evt) begin
      if (!push_data[9]) begin
        held       <= push_data[8:0];
        held_valid <= 1'b1;
      end else if (held_match) begin
        held_valid <= 1'b0;
      end
    end
  end

  assign wr_req = push_req && !filt_drop;
`else
  assign wr_req = push_req;
`endif

  // ---------------- event FIFO ----------------
  always_comb begin
    do_pop  = i_rd && (count != '0);
    do_push = wr_req && ((count != 7'(FIFO_DEPTH)) || do_pop);
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 7'd1;
        2'b01:   count <= count - 7'd1;
        default: count <= count;
      endcase
    end
  end

  // ---------------- status ----------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      o_ps2_enable <= 1'b0;
      o_overflow   <= 1'b0;
      o_err_count  <= '0;
    end else begin
      o_ps2_enable <= i_enable;
      if (i_clear) begin
        o_overflow  <= 1'b0;
        o_err_count <= '0;
      end else begin
        if (wr_req && !do_push) begin
          o_overflow <= 1'b1;
        end
        if (i_enable && i_error && (o_err_count != 8'hFF)) begin
          o_err_count <= o_err_count + 8'd1;
        end
      end
    end
  end

  assign o_empty = (count == '0);
  assign o_full  = (count == 7'(FIFO_DEPTH));
  assign o_count = count;
  assign o_event = o_empty ? '0 : mem[rd_ptr];

endmodule

// File: doc/ps2_key_ctrl.md
PS2_KEY_CTRL -- requirements
Module: ps2_key_ctrl

Interface
REQ-001 SHALL have parameter: FIFO_DEPTH, 8, event FIFO depth in entries (power of two, 2..64).
REQ-002 SHALL have port: clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous active-low reset; one clock; reset is synchronous and active-low.
REQ-004 SHALL have port: i_enable  input  1  controller enable; when low, incoming bytes are ignored and o_ps2_enable is low.
REQ-005 SHALL have port: o_ps2_enable  output  1  drives the PS/2 receiver enable; equals i_enable registered.
REQ-006 SHALL have port: i_key  input  8  scan-code byte from the receiver.
REQ-007 SHALL have port: i_key_valid  input  1  one-cycle strobe: i_key holds a good byte.
REQ-008 SHALL have port: i_error  input  1  one-cycle strobe: the receiver flagged a start, stop or parity error.
REQ-009 SHALL have port: i_rd  input  1  pop strobe from the host.
REQ-010 SHALL have port: i_clear  input  1  clears o_overflow and o_err_count.
REQ-011 SHALL have port: o_event  output  10  FIFO head as {break, extended, code[7:0]}; first-word fall-through.
REQ-012 SHALL have port: o_empty  output  1  FIFO empty.
REQ-013 SHALL have port: o_full  output  1  FIFO full.
REQ-014 SHALL have port: o_count  output  7  number of FIFO entries.
REQ-015 SHALL have port: o_overflow  output  1  sticky flag: an event was dropped because the FIFO was full.
REQ-016 SHALL have port: o_err_count  output  8  saturating count of i_error strobes.

Function
REQ-017 SHALL implement the decoder FSM states S_IDLE, S_E0, S_F0, S_E0F0 and S_PAUSE.
REQ-018 On a valid byte in S_IDLE: 0xE0 -> S_E0; 0xF0 -> S_F0; 0xE1 -> S_PAUSE with skip counter 7; any other byte pushes {0,0,byte} and stays in S_IDLE.
REQ-019 In S_E0: 0xF0 -> S_E0F0; any other byte pushes {0,1,byte} and returns to S_IDLE.
REQ-020 In S_F0, any byte pushes {1,0,byte} and returns to S_IDLE.
REQ-021 In S_E0F0, any byte pushes {1,1,byte} and returns to S_IDLE.
REQ-022 In S_PAUSE, each valid byte decrements the skip counter; at 0 the FSM pushes {0,1,0x77} and returns to S_IDLE; no event is pushed for the discarded bytes.
REQ-023 i_error SHALL force S_IDLE, discard any pending prefix, push nothing, and increment o_err_count, saturating at 255.
REQ-024 If i_error and i_key_valid arrive in the same cycle, i_error wins and the byte is discarded.
REQ-025 Latency: the event is written to the FIFO on the clock edge after its final byte strobe; o_empty falls in that same edge.
REQ-026 A pop with i_rd high and o_empty low SHALL advance the head on that edge; i_rd while empty is ignored.
REQ-027 A push while full without a simultaneous pop SHALL drop the event and set o_overflow; a push with a simultaneous pop while full succeeds and the count is unchanged.
REQ-028 A push and a pop in the same cycle on a non-empty FIFO SHALL leave o_count unchanged.
REQ-029 Read and write pointers SHALL wrap modulo FIFO_DEPTH; o_count ranges from 0 to FIFO_DEPTH.
REQ-030 While i_enable is low, i_key_valid and i_error SHALL be ignored, the FSM holds S_IDLE, and FIFO pops still operate.
REQ-031 i_clear SHALL zero o_overflow and o_err_count on the next edge; an error arriving in the same cycle is lost, because clear wins.

Reset
REQ-032 With reset low at a clock edge, the block SHALL set FSM to S_IDLE, skip counter to 0, pointers and o_count to 0, o_empty=1, o_full=0, o_overflow=0, o_err_count=0, o_ps2_enable=0 and o_event=0.
REQ-033 Reset mid-sequence (e.g. after 0xE0) SHALL discard the prefix and all FIFO contents.

Configuration
REQ-034 With macro PS2_KEY_CTRL_TYPEMATIC_FILTER_EN defined, the block SHALL hold the last make {extended, code} and drop a repeated identical make until its break is seen; the break clears the held value.
REQ-035 Without the macro, every make event SHALL be pushed, including typematic repeats, and no held register exists.

Verification
REQ-036 Bytes 0x1C, then 0xF0 0x1C -> FIFO holds 0x01C then 0x21C; o_count=2.
REQ-037 Bytes 0xE0 0x75, then 0xE0 0xF0 0x75 -> events 0x175 then 0x375.
REQ-038 Bytes 0xE1 0x14 0x77 0xE1 0xF0 0x14 0xF0 0x77 -> single event 0x177.
REQ-039 Bytes 0xE0, then an i_error strobe, then 0x1C -> event 0x01C, o_err_count=1.
REQ-040 FIFO_DEPTH=8: push 9 make codes with no pops -> o_full=1, o_count=8, o_overflow=1; then push and pop in the same cycle -> o_count stays 8.
REQ-041 With the filter macro: bytes 0x1C 0x1C 0x1C 0xF0 0x1C 0x1C -> events 0x01C, 0x21C, 0x01C; without the macro -> five events.
